cpu_run_ctrl: RTL and testbench

//  Run/step sequencer for the 16-bit single-cycle CPU. Gates CPU clock-enable and drives CPU reset.

---
 rtl/cpu_run_ctrl.sv | 160 ++++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_ctrl.sv
// Run/step sequencer for the 16-bit single-cycle CPU: gates CPU enable, drives CPU reset, tracks halt cause.
// Optional breakpoint support (bp_addr/bp_valid ports, cause 100) when RUN_CTRL_BREAKPOINT_EN is defined.
module cpu_run_ctrl #(
  parameter int unsigned PC_W     = 16,
  parameter int unsigned CYC_W    = 16,
  parameter logic [3:0]  HALT_OPC = 4'b1111,
  parameter int unsigned RST_CYC  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             step,
  input  logic             resume,
  input  logic             stop,
  input  logic [CYC_W-1:0] cycle_limit,
  input  logic [PC_W-1:0]  pc,
  input  logic [15:0]      instruction,
`ifdef RUN_CTRL_BREAKPOINT_EN
  input  logic [PC_W-1:0]  bp_addr,
  input  logic             bp_valid,
`endif
  output logic             cpu_en,
  output logic             cpu_rst,
  output logic             busy,
  output logic             done,
  output logic [2:0]       halt_cause,
  output logic [CYC_W-1:0] cycle_count
);

  localparam int unsigned RC_W = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

  localparam logic [2:0] CAUSE_NONE  = 3'b000;
  localparam logic [2:0] CAUSE_OPC   = 3'b001;
  localparam logic [2:0] CAUSE_LIMIT = 3'b010;
  localparam logic [2:0] CAUSE_STOP  = 3'b011;
  localparam logic [2:0] CAUSE_BP    = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE, S_RSTCPU, S_RUN, S_STEP, S_HALTED
  } state_t;

  state_t          state;
  logic [RC_W-1:0] rst_cnt;
  logic            skip_bp;
  logic            is_halt_opc;
  logic            limit_hit;
  logic            bp_hit;

  assign is_halt_opc = (instruction[15:12] == HALT_OPC);
  // Equality compare: a limit lowered below the current count never fires.
  assign limit_hit   = (cycle_limit != '0) && (cycle_count == cycle_limit);

`ifdef RUN_CTRL_BREAKPOINT_EN
  // Suppressed for the first RUN cycle after resume so the CPU can leave the breakpoint.
  assign bp_hit = bp_valid && (pc == bp_addr) && !skip_bp;
`else
  logic unused_bp;
  assign bp_hit    = 1'b0;
  assign unused_bp = ^{pc, skip_bp, CAUSE_BP};
`endif

  // CPU enable is decided in the same cycle the instruction is presented.
  always_comb begin
    cpu_en = 1'b0;
    case (state)
      S_RUN:   cpu_en = !is_halt_opc && !limit_hit && !bp_hit;
      S_STEP:  cpu_en = !is_halt_opc;
      default: cpu_en = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      rst_cnt     <= '0;
      skip_bp     <= 1'b0;
      cpu_rst     <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      halt_cause  <= CAUSE_NONE;
      cycle_count <= '0;
    end else begin
      done <= 1'b0;
      if (cpu_en && (cycle_count != '1))
        cycle_count <= cycle_count + CYC_W'(1);

      case (state)
        S_IDLE: begin
          if (start) begin
            state       <= S_RSTCPU;
            rst_cnt     <= '0;
            skip_bp     <= 1'b0;
            busy        <= 1'b1;
            halt_cause  <= CAUSE_NONE;
            cycle_count <= '0;
          end
        end

        S_RSTCPU: begin
          if (rst_cnt == RC_W'(RST_CYC - 1)) begin
            state   <= S_RUN;
            cpu_rst <= 1'b0;
          end else begin
            rst_cnt <= rst_cnt + RC_W'(1);
          end
        end

        S_RUN: begin
          skip_bp <= 1'b0;
          if (is_halt_opc || limit_hit || bp_hit || stop) begin
            state <= S_HALTED;
            busy  <= 1'b0;
            done  <= 1'b1;
            if (is_halt_opc)    halt_cause <= CAUSE_OPC;
            else if (limit_hit) halt_cause <= CAUSE_LIMIT;
`ifdef RUN_CTRL_BREAKPOINT_EN
            else if (bp_hit)    halt_cause <= CAUSE_BP;
`endif
            else                halt_cause <= CAUSE_STOP;
          end
        end

        S_STEP: begin
          state      <= S_HALTED;
          busy       <= 1'b0;
          done       <= 1'b1;
          halt_cause <= is_halt_opc ? CAUSE_OPC : CAUSE_NONE;
        end

        S_HALTED: begin
          // Start beats resume beats step.
          if (start) begin
            state       <= S_RSTCPU;
            rst_cnt     <= '0;
            skip_bp     <= 1'b0;
            cpu_rst     <= 1'b1;
            busy        <= 1'b1;
            halt_cause  <= CAUSE_NONE;
            cycle_count <= '0;
          end else if (resume) begin
            state      <= S_RUN;
            skip_bp    <= 1'b1;
            busy       <= 1'b1;
            halt_cause <= CAUSE_NONE;
          end else if (step) begin
            state <= S_STEP;
            busy  <= 1'b1;
          end
        end

        default: begin
          state   <= S_IDLE;
          cpu_rst <= 1'b1;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed self-checking bench for cpu_run_ctrl with a tiny PC model standing in for the CPU.
// Breakpoint checks are compiled in when RUN_CTRL_BREAKPOINT_EN is defined.
module tb_cpu_run_ctrl;

  logic        clk = 1'b0;
  logic        reset, start, step, resume, stop;
  logic [15:0] cycle_limit;
  logic [15:0] pc;
  logic [15:0] instruction;
  logic [15:0] halt_pc;
  logic [15:0] bp_addr;
  logic        bp_valid;
  logic        cpu_en, cpu_rst, busy, done;
  logic [2:0]  halt_cause;
  logic [15:0] cycle_count;

  int total = 0;
  int bad   = 0;
  int en_n;
  int rst_n_cyc;

  always #5 clk = ~clk;

  cpu_run_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .step        (step),
    .resume      (resume),
    .stop        (stop),
    .cycle_limit (cycle_limit),
    .pc          (pc),
    .instruction (instruction),
`ifdef RUN_CTRL_BREAKPOINT_EN
    .bp_addr     (bp_addr),
    .bp_valid    (bp_valid),
`endif
    .cpu_en      (cpu_en),
    .cpu_rst     (cpu_rst),
    .busy        (busy),
    .done        (done),
    .halt_cause  (halt_cause),
    .cycle_count (cycle_count)
  );

  // Minimal CPU: PC advances on each enabled cycle, halt opcode sits at halt_pc.
  always @(posedge clk) begin
    if (cpu_rst)     pc <= 16'd0;
    else if (cpu_en) pc <= pc + 16'd1;
  end
  assign instruction = (pc == halt_pc) ? 16'hF000 : 16'h1234;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Counts enabled cycles until done is seen, bounded.
  task automatic wait_done(input int max, output int en_cycles);
    en_cycles = 0;
    for (int i = 0; i < max && done !== 1'b1; i++) begin
      if (cpu_en === 1'b1) en_cycles++;
      tick();
    end
    chk("done_seen", done, 1);
  endtask

  task automatic wait_rst_release();
    for (int i = 0; i < 20 && cpu_rst !== 1'b0; i++) tick();
    chk("rst_release", cpu_rst, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; step = 1'b0; resume = 1'b0; stop = 1'b0;
    cycle_limit = 16'd0; halt_pc = 16'd5; bp_addr = 16'd0; bp_valid = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    chk("rst_cpu_rst", cpu_rst, 1);
    chk("rst_cpu_en", cpu_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cause", halt_cause, 0);
    chk("rst_count", cycle_count, 0);

    // Halt opcode at pc 5
    start = 1'b1; tick(); start = 1'b0;
    chk("rstcpu_busy", busy, 1);
    rst_n_cyc = 0;
    for (int i = 0; i < 10 && cpu_rst === 1'b1; i++) begin
      rst_n_cyc++;
      tick();
    end
    chk("rstcpu_len", rst_n_cyc, 2);
    wait_done(50, en_n);
    chk("opc_en_cycles", en_n, 5);
    chk("opc_cause", halt_cause, 3'b001);
    chk("opc_count", cycle_count, 5);
    chk("opc_busy", busy, 0);
    chk("opc_halted_en", cpu_en, 0);
    tick();
    chk("done_one_cycle", done, 0);

    // Step onto a halt opcode does not execute
    step = 1'b1; tick(); step = 1'b0;
    chk("step_opc_en", cpu_en, 0);
    chk("step_opc_busy", busy, 1);
    tick();
    chk("step_opc_done", done, 1);
    chk("step_opc_cause", halt_cause, 3'b001);
    chk("step_opc_count", cycle_count, 5);

    // Cycle limit
    halt_pc = 16'hFFFF; cycle_limit = 16'd3;
    start = 1'b1; tick(); start = 1'b0;
    wait_done(50, en_n);
    chk("lim_en_cycles", en_n, 3);
    chk("lim_cause", halt_cause, 3'b010);
    chk("lim_count", cycle_count, 3);

    // Resume keeps the count; raised limit runs two more cycles
    cycle_limit = 16'd5;
    resume = 1'b1; tick(); resume = 1'b0;
    chk("resume_cause_clr", halt_cause, 0);
    chk("resume_busy", busy, 1);
    wait_done(50, en_n);
    chk("resume_en_cycles", en_n, 2);
    chk("resume_count", cycle_count, 5);
    chk("resume_cause", halt_cause, 3'b010);

    // Limit lowered below count does not halt
    cycle_limit = 16'd2;
    resume = 1'b1; tick(); resume = 1'b0;
    tick(); tick();
    chk("low_limit_runs", cpu_en, 1);
    stop = 1'b1; tick(); stop = 1'b0;
    chk("low_limit_cause", halt_cause, 3'b011);
    chk("low_limit_count", cycle_count, 8);
    chk("low_limit_done", done, 1);

    // Stop on the 4th RUN cycle, then single step
    cycle_limit = 16'd0;
    start = 1'b1; tick(); start = 1'b0;
    wait_rst_release();
    tick(); tick(); tick();
    stop = 1'b1;
    chk("stop_cycle_en", cpu_en, 1);
    tick(); stop = 1'b0;
    chk("stop_cause", halt_cause, 3'b011);
    chk("stop_count", cycle_count, 4);
    chk("stop_done", done, 1);
    step = 1'b1; tick(); step = 1'b0;
    chk("step_en", cpu_en, 1);
    tick();
    chk("step_done", done, 1);
    chk("step_count", cycle_count, 5);
    chk("step_cause", halt_cause, 0);
    chk("step_halted_en", cpu_en, 0);

    // Start beats step in HALTED; start in RUN ignored
    start = 1'b1; step = 1'b1; tick(); start = 1'b0; step = 1'b0;
    chk("prio_cpu_rst", cpu_rst, 1);
    chk("prio_busy", busy, 1);
    chk("prio_count", cycle_count, 0);
    wait_rst_release();
    tick();
    start = 1'b1; tick(); start = 1'b0;
    chk("run_start_rst", cpu_rst, 0);
    chk("run_start_en", cpu_en, 1);
    chk("run_start_count", cycle_count, 2);

    // Reset mid-run, then step/resume in IDLE ignored
    reset = 1'b1; tick(); reset = 1'b0;
    chk("midrst_en", cpu_en, 0);
    chk("midrst_cpu_rst", cpu_rst, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_cause", halt_cause, 0);
    chk("midrst_done", done, 0);
    step = 1'b1; resume = 1'b1; tick(); step = 1'b0; resume = 1'b0;
    chk("idle_step_busy", busy, 0);
    chk("idle_step_en", cpu_en, 0);
    chk("idle_step_rst", cpu_rst, 1);

`ifdef RUN_CTRL_BREAKPOINT_EN
    // Breakpoint at pc 4, resume executes past it
    bp_addr = 16'd4; bp_valid = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    wait_done(50, en_n);
    chk("bp_en_cycles", en_n, 4);
    chk("bp_cause", halt_cause, 3'b100);
    chk("bp_count", cycle_count, 4);
    resume = 1'b1; tick(); resume = 1'b0;
    chk("bp_resume_exec", cpu_en, 1);
    tick();
    chk("bp_resume_cont", cpu_en, 1);
    stop = 1'b1; tick(); stop = 1'b0;
    chk("bp_stop_cause", halt_cause, 3'b011);
    chk("bp_stop_count", cycle_count, 6);
    bp_valid = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
